// File: rtl/picorv_bus_arbiter.sv
// Round-robin arbiter sharing one picorv32 native memory port between up to four masters.
// The grant is held for one full transfer; a watchdog force-completes a stalled transfer.
module picorv_bus_arbiter #(
    parameter int          NUM_MASTERS    = 2,
    parameter int          TIMEOUT_CYCLES = 256,
    parameter logic [31:0] ERR_DATA       = 32'hDEAD_BEEF
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic [NUM_MASTERS-1:0]    m_valid,
    input  logic [NUM_MASTERS-1:0]    m_instr,
    input  logic [32*NUM_MASTERS-1:0] m_addr,
    input  logic [32*NUM_MASTERS-1:0] m_wdata,
    input  logic [4*NUM_MASTERS-1:0]  m_wstrb,
    output logic [NUM_MASTERS-1:0]    m_ready,
    output logic [31:0]               m_rdata,
    output logic                      s_valid,
    output logic                      s_instr,
    output logic [31:0]               s_addr,
    output logic [31:0]               s_wdata,
    output logic [3:0]                s_wstrb,
    input  logic                      s_ready,
    input  logic [31:0]               s_rdata,
    output logic [NUM_MASTERS-1:0]    grant,
    output logic                      timeout_flag
);

    localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t                 state, state_nxt;
    logic [NUM_MASTERS-1:0] grant_nxt;
    logic [IW-1:0]          last, last_nxt;
    logic [CW-1:0]          wd_cnt, wd_cnt_nxt;
    logic                   flag_nxt;
    logic [IW-1:0]          owner;
    logic [NUM_MASTERS-1:0] req_rot;
    logic [IW-1:0]          pick;
    logic                   pick_found;
    logic                   wd_expired;

    generate
        if (TIMEOUT_CYCLES > 0) begin : g_wd
            assign wd_expired = (wd_cnt == CW'(TIMEOUT_CYCLES - 1));
        end else begin : g_no_wd
            assign wd_expired = 1'b0;
        end
    endgenerate

    always_comb begin
        owner = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (grant[i]) owner = IW'(i);
        end
    end

    // Rotate requests so bit 0 is the master just after the last one served.
    assign req_rot = NUM_MASTERS'({m_valid, m_valid} >> (int'(last) + 1));

    always_comb begin
        pick_found = 1'b0;
        pick       = '0;
        for (int j = NUM_MASTERS - 1; j >= 0; j--) begin
            if (req_rot[j]) begin
                pick_found = 1'b1;
                pick       = IW'((int'(last) + 1 + j) % NUM_MASTERS);
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= IDLE;
            grant        <= '0;
            last         <= IW'(NUM_MASTERS - 1);
            wd_cnt       <= '0;
            timeout_flag <= 1'b0;
        end else begin
            state        <= state_nxt;
            grant        <= grant_nxt;
            last         <= last_nxt;
            wd_cnt       <= wd_cnt_nxt;
            timeout_flag <= flag_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        grant_nxt  = grant;
        last_nxt   = last;
        wd_cnt_nxt = wd_cnt;
        flag_nxt   = timeout_flag;
        s_valid    = 1'b0;
        s_instr    = 1'b0;
        s_addr     = '0;
        s_wdata    = '0;
        s_wstrb    = '0;
        m_ready    = '0;
        m_rdata    = '0;

        // One-hot AND-OR mux: all zero whenever grant is empty.
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (grant[i]) begin
                s_instr = s_instr | m_instr[i];
                s_addr  = s_addr  | m_addr[32*i +: 32];
                s_wdata = s_wdata | m_wdata[32*i +: 32];
                s_wstrb = s_wstrb | m_wstrb[4*i +: 4];
            end
        end

        case (state)
            IDLE: begin
                if (pick_found) begin
                    grant_nxt  = NUM_MASTERS'(1) << pick;
                    wd_cnt_nxt = '0;
                    state_nxt  = BUSY;
                end
            end
            BUSY: begin
                s_valid = |(m_valid & grant);
                if (!s_valid || s_ready || wd_expired) begin
                    state_nxt  = IDLE;
                    grant_nxt  = '0;
                    last_nxt   = owner;
                    wd_cnt_nxt = '0;
                end else begin
                    wd_cnt_nxt = wd_cnt + 1'b1;
                end
                // A real completion beats a same-cycle watchdog expiry.
                if (s_valid && s_ready) begin
                    m_ready = grant;
                    m_rdata = s_rdata;
                end else if (s_valid && wd_expired) begin
                    m_ready  = grant;
                    m_rdata  = ERR_DATA;
                    flag_nxt = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_picorv_bus_arbiter.sv
// Bench for picorv_bus_arbiter: directed scenarios plus random traffic checked
// against a transaction-level reference model of the arbitration rules.
module tb_picorv_bus_arbiter;

    localparam int          NM  = 2;
    localparam int          TO  = 8;
    localparam logic [31:0] ERR = 32'hDEAD_BEEF;

    logic            clk = 1'b0;
    logic            resetn;
    logic [NM-1:0]   m_valid, m_instr, m_ready, grant;
    logic [32*NM-1:0] m_addr, m_wdata;
    logic [4*NM-1:0] m_wstrb;
    logic [31:0]     m_rdata, s_addr, s_wdata, s_rdata;
    logic            s_valid, s_instr, s_ready, timeout_flag;
    logic [3:0]      s_wstrb;

    picorv_bus_arbiter #(.NUM_MASTERS(NM), .TIMEOUT_CYCLES(TO), .ERR_DATA(ERR)) dut (
        .clk(clk), .resetn(resetn),
        .m_valid(m_valid), .m_instr(m_instr), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_wstrb(m_wstrb), .m_ready(m_ready), .m_rdata(m_rdata),
        .s_valid(s_valid), .s_instr(s_instr), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_wstrb(s_wstrb), .s_ready(s_ready), .s_rdata(s_rdata),
        .grant(grant), .timeout_flag(timeout_flag)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: which master owns the port (-1 = none), who was served last,
    // how many stalled owner cycles have elapsed, and the sticky timeout.
    int            owner;
    int            last_srv;
    int            stall_n;
    bit            flag;
    logic [NM-1:0] exp_ready;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        owner     = -1;
        last_srv  = NM - 1;
        stall_n   = 0;
        flag      = 0;
        exp_ready = '0;
    endtask

    // Called just after a falling edge with inputs already driven.
    task automatic step();
        logic [31:0] e_addr, e_wdata, e_rdata;
        logic [3:0]  e_wstrb;
        logic        e_sv, e_si;
        logic [NM-1:0] e_gr, e_rdy;
        bit done, tmo;
        #1;
        e_addr = '0; e_wdata = '0; e_rdata = '0; e_wstrb = '0; e_sv = 0; e_si = 0;
        e_gr = '0; e_rdy = '0; done = 0; tmo = 0;
        if (owner >= 0) begin
            e_gr    = NM'(1) << owner;
            e_sv    = m_valid[owner];
            e_si    = m_instr[owner];
            e_addr  = m_addr[32*owner +: 32];
            e_wdata = m_wdata[32*owner +: 32];
            e_wstrb = m_wstrb[4*owner +: 4];
            if (!m_valid[owner]) done = 1;
            else if (s_ready) begin e_rdy = e_gr; e_rdata = s_rdata; done = 1; end
            else if (stall_n == TO - 1) begin e_rdy = e_gr; e_rdata = ERR; done = 1; tmo = 1; end
        end
        exp_ready = e_rdy;
        chk("grant", 32'(grant), 32'(e_gr));
        chk("s_valid", 32'(s_valid), 32'(e_sv));
        chk("s_instr", 32'(s_instr), 32'(e_si));
        chk("s_addr", s_addr, e_addr);
        chk("s_wdata", s_wdata, e_wdata);
        chk("s_wstrb", 32'(s_wstrb), 32'(e_wstrb));
        chk("m_ready", 32'(m_ready), 32'(e_rdy));
        chk("m_rdata", m_rdata, e_rdata);
        chk("timeout_flag", 32'(timeout_flag), 32'(flag));
        @(posedge clk);
        if (owner < 0) begin
            for (int k = 1; k <= NM; k++) begin
                if (owner < 0 && m_valid[(last_srv + k) % NM]) begin
                    owner   = (last_srv + k) % NM;
                    stall_n = 0;
                end
            end
        end else if (done) begin
            last_srv = owner;
            owner    = -1;
            if (tmo) flag = 1;
        end else begin
            stall_n++;
        end
        @(negedge clk);
    endtask

    // Asynchronous reset asserted between edges; outputs must clear immediately.
    task automatic do_reset();
        resetn = 1'b0;
        #1;
        chk("rst_s_valid", 32'(s_valid), 0);
        chk("rst_m_ready", 32'(m_ready), 0);
        chk("rst_grant", 32'(grant), 0);
        chk("rst_s_addr", s_addr, 0);
        chk("rst_m_rdata", m_rdata, 0);
        chk("rst_flag", 32'(timeout_flag), 0);
        model_reset();
        @(negedge clk);
        resetn = 1'b1;
    endtask

    initial begin
        logic [7:0] seq;
        bit stall_mode;
        resetn = 1'b1;
        m_valid = '0; m_instr = '0; m_addr = '0; m_wdata = '0; m_wstrb = '0;
        s_ready = 1'b0; s_rdata = '0;
        model_reset();
        #2;
        do_reset();

        // Reset mid-transfer, then a clean read by master 0.
        m_valid = 2'b01; m_addr[31:0] = 32'h100;
        step(); step();
        chk("mid_busy_s_valid", 32'(s_valid), 1);
        #2;
        do_reset();
        s_ready = 1'b1; s_rdata = 32'h1234_5678;
        step();
        #1;
        chk("rd_m_ready", 32'(m_ready), 32'h1);
        chk("rd_m_rdata", m_rdata, 32'h1234_5678);
        step();
        m_valid = '0; s_ready = 1'b0;
        step();

        // Round-robin with both masters always requesting and a zero-wait slave.
        do_reset();
        m_valid = 2'b11; m_addr = {32'h20, 32'h10}; s_ready = 1'b1; s_rdata = 32'h55;
        seq = '0;
        for (int t = 0; t < 4; t++) begin
            step();
            #1;
            seq = {seq[5:0], grant};
            chk("rr_s_addr", s_addr, (t % 2) ? 32'h20 : 32'h10);
            step();
        end
        chk("rr_seq", 32'(seq), 32'b01_10_01_10);
        m_valid = '0; s_ready = 1'b0;
        step();

        // Write from master 1 with three wait states.
        m_valid = 2'b10; m_addr[63:32] = 32'h1000_0000; m_wdata[63:32] = 32'hA5;
        m_wstrb = 8'b0001_0000;
        step(); step(); step(); step();
        s_ready = 1'b1;
        #1;
        chk("wr_m_ready", 32'(m_ready), 32'h2);
        step();
        m_valid = '0; s_ready = 1'b0; m_wstrb = '0;
        step();

        // Watchdog expiry on the 8th stalled cycle; flag survives later good transfers.
        do_reset();
        m_valid = 2'b01; m_addr[31:0] = 32'h200;
        step();
        for (int c = 0; c < TO - 1; c++) step();
        #1;
        chk("to_m_ready", 32'(m_ready), 32'h1);
        chk("to_m_rdata", m_rdata, ERR);
        step();
        chk("to_flag_set", 32'(timeout_flag), 1);
        m_valid = '0;
        step();
        m_valid = 2'b01; s_ready = 1'b1; s_rdata = 32'h77;
        step(); step();
        m_valid = '0; s_ready = 1'b0;
        step();
        chk("to_flag_sticky", 32'(timeout_flag), 1);

        // Real completion on the expiry cycle wins.
        do_reset();
        m_valid = 2'b01;
        step();
        for (int c = 0; c < TO - 1; c++) step();
        s_ready = 1'b1; s_rdata = 32'hCAFE_F00D;
        #1;
        chk("race_m_rdata", m_rdata, 32'hCAFE_F00D);
        step();
        m_valid = '0; s_ready = 1'b0;
        step();
        chk("race_flag", 32'(timeout_flag), 0);

        // Abort by master 0 with master 1 waiting.
        do_reset();
        m_valid = 2'b11;
        step(); step(); step();
        m_valid[0] = 1'b0;
        #1;
        chk("abort_no_ready", 32'(m_ready), 0);
        step(); step();
        chk("abort_grant", 32'(grant), 32'h2);
        s_ready = 1'b1;
        step();
        m_valid = '0; s_ready = 1'b0;
        step();

        // Random traffic: masters hold requests until served, occasionally abort.
        do_reset();
        stall_mode = 0;
        for (int n = 0; n < 3000; n++) begin
            if (n % 150 == 0) stall_mode = ($urandom_range(0, 3) == 0);
            for (int i = 0; i < NM; i++) begin
                if (exp_ready[i]) begin
                    m_valid[i] = 1'b0;
                end else if (!m_valid[i]) begin
                    if ($urandom_range(0, 1) == 1) begin
                        m_valid[i]          = 1'b1;
                        m_instr[i]          = 1'($urandom_range(0, 1));
                        m_addr[32*i +: 32]  = $urandom;
                        m_wdata[32*i +: 32] = $urandom;
                        m_wstrb[4*i +: 4]   = 4'($urandom_range(0, 15));
                    end
                end else if ($urandom_range(0, 31) == 0) begin
                    m_valid[i] = 1'b0;
                end
            end
            s_ready = stall_mode ? 1'b0 : ($urandom_range(0, 2) == 0);
            s_rdata = $urandom;
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/picorv_bus_arbiter.md
Name: picorv_bus_arbiter

Overview:
- Shares one picorv32 native memory port (valid/ready/addr/wdata/wstrb/rdata) between up to 4 bus masters, e.g. two picorv32 cores or a core plus a stream DMA engine, in front of a single picorv_mem instance.
- Round-robin grant, held for one complete transfer.
- Watchdog timeout completes a stalled transfer with an error word so a master never hangs.

Parameters:
- NUM_MASTERS, 2, number of masters (legal range 1..4).
- TIMEOUT_CYCLES, 256, BUSY cycles without s_ready before forced completion; 0 disables the watchdog.
- ERR_DATA, 32'hDEAD_BEEF, rdata returned on a timed-out transfer.

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- m_valid  in  NUM_MASTERS  per-master request valid
- m_instr  in  NUM_MASTERS  per-master instruction-fetch flag
- m_addr  in  32*NUM_MASTERS  per-master address, master i at bits [32i+31:32i]
- m_wdata  in  32*NUM_MASTERS  per-master write data
- m_wstrb  in  4*NUM_MASTERS  per-master byte strobes (0 = read)
- m_ready  out  NUM_MASTERS  per-master completion pulse
- m_rdata  out  32  read data, broadcast; valid only for the master whose m_ready is high
- s_valid  out  1  slave request valid
- s_instr  out  1  slave instruction flag
- s_addr  out  32  slave address
- s_wdata  out  32  slave write data
- s_wstrb  out  4  slave strobes
- s_ready  in  1  slave completion
- s_rdata  in  32  slave read data
- grant  out  NUM_MASTERS  one-hot current owner (registered)
- timeout_flag  out  1  sticky, set on any watchdog completion

Behaviour:
- Reset (asynchronous, any time, including mid-transfer):
  - Goes to IDLE.
  - grant=0, timeout_flag=0, watchdog count=0.
  - last-served pointer = NUM_MASTERS-1, so master 0 has first priority.
  - All outputs deassert immediately: s_valid=0, m_ready=0, s_addr/s_wdata/s_wstrb/s_instr=0, m_rdata=0.
- States: IDLE, BUSY.
- IDLE:
  - If any m_valid is high, select the first requester scanning from (last+1) mod NUM_MASTERS upward with wrap.
  - Register that master as the one-hot grant and go to BUSY. This costs 1 arbitration cycle.
  - In IDLE, s_valid=0 and m_ready=0.
- BUSY (owner g):
  - s_valid = m_valid[g]. s_instr/s_addr/s_wdata/s_wstrb are muxed combinationally from master g. They are 0 when grant=0.
  - s_ready=1: m_ready[g]=1 in the same cycle, m_rdata=s_rdata. Next state IDLE; last=g; grant cleared; watchdog cleared.
  - Watchdog: the counter increments each BUSY cycle without s_ready. When the counter reaches TIMEOUT_CYCLES-1 and s_ready=0:
    - m_ready[g]=1 and m_rdata=ERR_DATA for that cycle.
    - timeout_flag set (sticky until reset).
    - Go to IDLE; last=g.
  - s_ready and timeout in the same cycle: the real completion wins, rdata=s_rdata, and the flag is not set.
  - m_valid[g] drops while BUSY (protocol abort): go to IDLE with no m_ready pulse; last=g; the watchdog clears.
- Non-granted masters never see m_ready. Their requests wait; there is no starvation, because each master is reached within NUM_MASTERS grants.
- Throughput: at most one transfer per 2 cycles with a 0-wait-state slave. A transfer is 1 arbitration cycle + ≥1 BUSY cycle.
- NUM_MASTERS=1 still inserts the IDLE cycle.
- Never more than one m_ready bit high. m_ready is never high while in IDLE.

Test Plan:
- Reset mid-transfer: master0 granted, BUSY, s_ready=0; pull resetn low → s_valid, m_ready, grant all 0 in the same cycle. After release, master0 read addr 0x100 with s_rdata=0x1234_5678 → m_ready[0] pulses one cycle, m_rdata=0x1234_5678.
- Round-robin: m_valid=2'b11 held, slave always ready → grant sequence 01,10,01,10. One m_ready every 2 cycles, alternating masters. s_addr matches the owner's address (0x10 vs 0x20).
- Write routing: master1 addr 0x1000_0000, wdata 0xA5, wstrb 4'b0001, s_ready after 3 wait cycles → s_* show master1's values for 4 BUSY cycles. m_ready[1] rises only in the 4th. m_ready[0] stays 0 throughout.
- Timeout: TIMEOUT_CYCLES=8, s_ready held 0 → m_ready[0] high on the 8th BUSY cycle, m_rdata=0xDEAD_BEEF, timeout_flag=1 and stays 1 across later good transfers.
- Race: s_ready asserted on exactly the 8th BUSY cycle → m_rdata=s_rdata and timeout_flag remains 0.
- Abort: master0 drops m_valid after 2 BUSY cycles with master1 pending → no m_ready[0]. grant becomes 10 two cycles later.
